// File: rtl/rcp_seq.sv
// Multi-cycle fixed-point reciprocal: R = floor(2^WIDTH / a).
// Power-of-two seed, ITERS Newton-Raphson steps, then a +/-1 correction loop.
module rcp_seq #(
  parameter int WIDTH = 16,
  parameter int ITERS = 3
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             v_i,
  input  logic [WIDTH-1:0] a_i,
  output logic             ready_o,
  output logic             v_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] r_o,
  output logic             dz_o,
  output logic             sat_o
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_SEED = 3'd1;
  localparam logic [2:0] S_ITER = 3'd2;
  localparam logic [2:0] S_CORR = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  localparam int PW = 2*WIDTH + 3;
  localparam int CW = (ITERS > 1) ? $clog2(ITERS) : 1;

  localparam logic [PW-1:0]  ONE_P     = PW'(1) << WIDTH;
  localparam logic [PW-1:0]  TWO_P     = PW'(1) << (WIDTH + 1);
  localparam logic [WIDTH:0] EST_MAX   = (WIDTH+1)'(1) << WIDTH;
  localparam logic [WIDTH:0] EST_ONE   = (WIDTH+1)'(1);
  localparam logic [CW-1:0]  CNT_LAST  = CW'(ITERS - 1);

  logic [2:0]       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH:0]   est_q, est_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic             dz_q, dz_d;
  logic             sat_q, sat_d;
  logic             v_q, v_d;

  logic [PW-1:0]    p;
  logic [PW-1:0]    d;
  logic [PW-1:0]    prod;
  logic [PW-1:0]    est_nr;
  logic [WIDTH:0]   est_iter;
  logic [WIDTH:0]   seed;
  logic             accept;

  assign ready_o = (state_q == S_IDLE) && !rst_i;
  assign accept  = v_i && ready_o;
  assign v_o     = v_q;
  assign r_o     = r_q;
  assign dz_o    = dz_q;
  assign sat_o   = sat_q;

  // Shared multiplier datapath; operands are zero-extended to PW bits.
  always_comb begin
    p      = PW'(a_q) * PW'(est_q);
    d      = TWO_P - p;
    prod   = PW'(est_q) * d;
    est_nr = prod >> WIDTH;
    if (est_nr > ONE_P) begin
      est_iter = EST_MAX;
    end else if (est_nr == '0) begin
      est_iter = EST_ONE;
    end else begin
      est_iter = est_nr[WIDTH:0];
    end
  end

  // Ascending scan: the highest set bit of a_q is the last one to write the seed.
  always_comb begin
    seed = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (a_q[i]) begin
        seed = EST_ONE << (WIDTH - i);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    est_d   = est_q;
    cnt_d   = cnt_q;
    r_d     = r_q;
    dz_d    = dz_q;
    sat_d   = sat_q;
    v_d     = v_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          a_d = a_i;
          if (a_i == '0) begin
            r_d     = '1;
            dz_d    = 1'b1;
            sat_d   = 1'b0;
            v_d     = 1'b1;
            state_d = S_DONE;
          end else if (a_i == WIDTH'(1)) begin
            r_d     = '1;
            dz_d    = 1'b0;
            sat_d   = 1'b1;
            v_d     = 1'b1;
            state_d = S_DONE;
          end else begin
            state_d = S_SEED;
          end
        end
      end
      S_SEED: begin
        est_d   = seed;
        cnt_d   = '0;
        state_d = S_ITER;
      end
      S_ITER: begin
        est_d = est_iter;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CNT_LAST) begin
          state_d = S_CORR;
        end
      end
      S_CORR: begin
        if (p > ONE_P) begin
          est_d = est_q - EST_ONE;
        end else if (p + PW'(a_q) <= ONE_P) begin
          est_d = est_q + EST_ONE;
        end else begin
          r_d     = est_q[WIDTH-1:0];
          dz_d    = 1'b0;
          sat_d   = 1'b0;
          v_d     = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (ready_i) begin
          v_d     = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        v_d     = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      est_q   <= '0;
      cnt_q   <= '0;
      r_q     <= '0;
      dz_q    <= 1'b0;
      sat_q   <= 1'b0;
      v_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      est_q   <= est_d;
      cnt_q   <= cnt_d;
      r_q     <= r_d;
      dz_q    <= dz_d;
      sat_q   <= sat_d;
      v_q     <= v_d;
    end
  end

endmodule

// File: tb/tb_rcp_seq.sv
// Directed and sweep checks of rcp_seq at WIDTH=16/ITERS=3 and WIDTH=8/ITERS=1.
module tb_rcp_seq;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        v_i, ready_i;
  logic [15:0] a_i;
  logic        ready_o, v_o, dz_o, sat_o;
  logic [15:0] r_o;

  logic        v8_i, ready8_i;
  logic [7:0]  a8_i;
  logic        ready8_o, v8_o, dz8_o, sat8_o;
  logic [7:0]  r8_o;

  int checks = 0;
  int errors = 0;

  rcp_seq #(.WIDTH(16), .ITERS(3)) u_dut16 (
    .clk_i(clk), .rst_i(rst), .v_i(v_i), .a_i(a_i), .ready_o(ready_o),
    .v_o(v_o), .ready_i(ready_i), .r_o(r_o), .dz_o(dz_o), .sat_o(sat_o)
  );

  rcp_seq #(.WIDTH(8), .ITERS(1)) u_dut8 (
    .clk_i(clk), .rst_i(rst), .v_i(v8_i), .a_i(a8_i), .ready_o(ready8_o),
    .v_o(v8_o), .ready_i(ready8_i), .r_o(r8_o), .dz_o(dz8_o), .sat_o(sat8_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
    end
  endtask

  function automatic int ref_rcp(input int w, input int a);
    if (a <= 1) return (1 << w) - 1;
    return (1 << w) / a;
  endfunction

  task automatic do_op(input bit sel, input int a, output int r, output int dz,
                       output int sat, output int lat);
    int w;
    int n;
    w = sel ? 8 : 16;
    n = 0;
    while (!(sel ? ready8_o : ready_o) && n < 16) begin
      @(posedge clk); #1;
      n++;
    end
    chk($sformatf("ready_before_accept w=%0d a=%0d", w, a), sel ? ready8_o : ready_o, 1);
    if (sel) begin
      v8_i = 1'b1;
      a8_i = a[7:0];
    end else begin
      v_i = 1'b1;
      a_i = a[15:0];
    end
    @(posedge clk); #1;
    v_i  = 1'b0;
    v8_i = 1'b0;
    lat  = 0;
    while (!(sel ? v8_o : v_o) && lat < (1 << w) + 4) begin
      @(posedge clk); #1;
      lat++;
    end
    chk($sformatf("v_o_timeout w=%0d a=%0d", w, a), sel ? v8_o : v_o, 1);
    r   = sel ? int'(r8_o) : int'(r_o);
    dz  = sel ? int'(dz8_o) : int'(dz_o);
    sat = sel ? int'(sat8_o) : int'(sat_o);
    if (sel) ready8_i = 1'b1;
    else     ready_i  = 1'b1;
    @(posedge clk); #1;
    ready_i  = 1'b0;
    ready8_i = 1'b0;
    chk($sformatf("v_o_after_xfer w=%0d a=%0d", w, a), sel ? v8_o : v_o, 0);
  endtask

  task automatic run_case(input bit sel, input int a, input int exp_r, input int exp_lat);
    int r, dz, sat, lat, w, its;
    w   = sel ? 8 : 16;
    its = sel ? 1 : 3;
    do_op(sel, a, r, dz, sat, lat);
    chk($sformatf("r w=%0d a=%0d", w, a), r, exp_r);
    chk($sformatf("dz w=%0d a=%0d", w, a), dz, (a == 0));
    chk($sformatf("sat w=%0d a=%0d", w, a), sat, (a == 1));
    if (a >= 2) chk($sformatf("lat_min w=%0d a=%0d lat=%0d", w, a, lat), (lat >= its + 2), 1);
    chk($sformatf("lat_max w=%0d a=%0d lat=%0d", w, a, lat), (lat <= (1 << w)), 1);
    if (exp_lat >= 0) chk($sformatf("lat_exact w=%0d a=%0d", w, a), lat, exp_lat);
  endtask

  initial begin
    int n;
    int ghost;
    int acc;
    int xfers;
    int a;
    logic [15:0] res[$];

    rst = 1'b1; v_i = 1'b0; ready_i = 1'b0; a_i = '0;
    v8_i = 1'b0; ready8_i = 1'b0; a8_i = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready_o", ready_o, 0);
    chk("rst_v_o", v_o, 0);
    chk("rst_r_o", r_o, 0);
    chk("rst_dz_o", dz_o, 0);
    chk("rst_sat_o", sat_o, 0);
    rst = 1'b0;
    #1;
    chk("ready_after_rst", ready_o, 1);

    // Directed WIDTH=16 cases; exact latencies worked out by hand.
    run_case(0, 3,      16'h5555, 90);
    run_case(0, 2,      16'h8000, 5);
    run_case(0, 16'h8000, 2,      5);
    run_case(0, 16'hFFFF, 1,      5);
    run_case(0, 7,      9362,     -1);
    run_case(0, 0,      16'hFFFF, 0);
    run_case(0, 1,      16'hFFFF, 0);

    // Backpressure with a=5: outputs frozen, v_i pulses ignored.
    chk("bp_ready_before", ready_o, 1);
    v_i = 1'b1; a_i = 16'd5;
    @(posedge clk); #1;
    v_i = 1'b0;
    n = 0;
    while (!v_o && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("bp_v_o_rise", v_o, 1);
    for (int i = 0; i < 6; i++) begin
      v_i = (i % 2 == 0);
      a_i = 16'd3;
      @(posedge clk); #1;
      chk($sformatf("bp_r_o c%0d", i), r_o, 13107);
      chk($sformatf("bp_v_o c%0d", i), v_o, 1);
      chk($sformatf("bp_ready_o c%0d", i), ready_o, 0);
    end
    v_i = 1'b0; ready_i = 1'b1;
    @(posedge clk); #1;
    ready_i = 1'b0;
    chk("bp_v_o_drop", v_o, 0);
    chk("bp_ready_back", ready_o, 1);
    chk("bp_r_o_held", r_o, 13107);

    // Reset during ITER discards the operand.
    v_i = 1'b1; a_i = 16'd3;
    @(posedge clk); #1;
    v_i = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("mid_rst_ready_o", ready_o, 1);
    chk("mid_rst_v_o", v_o, 0);
    chk("mid_rst_r_o", r_o, 0);
    ghost = 0;
    for (int i = 0; i < 120; i++) begin
      @(posedge clk); #1;
      if (v_o) ghost++;
    end
    chk("mid_rst_ghost_v_o", ghost, 0);
    run_case(0, 7, 9362, -1);

    // Back-to-back with ready_i held high.
    acc = 0; xfers = 0;
    ready_i = 1'b1; v_i = 1'b1; a_i = 16'd10;
    for (int i = 0; i < 300; i++) begin
      bit will_acc;
      will_acc = v_i && ready_o;
      if (v_o && ready_i) begin
        res.push_back(r_o);
        xfers++;
      end
      @(posedge clk); #1;
      if (will_acc) begin
        acc++;
        if (acc == 1) a_i = 16'd1000;
        else          v_i = 1'b0;
      end
    end
    ready_i = 1'b0;
    chk("b2b_accepts", acc, 2);
    chk("b2b_xfers", xfers, 2);
    if (res.size() >= 2) begin
      chk("b2b_r0", res[0], 6553);
      chk("b2b_r1", res[1], 65);
    end else begin
      chk("b2b_result_count", res.size(), 2);
    end

    // Random sweep at WIDTH=16.
    for (int i = 0; i < 300; i++) begin
      a = $urandom_range(0, 65535);
      run_case(0, a, ref_rcp(16, a), -1);
    end

    // WIDTH=8, ITERS=1: a=3 latency by hand, then every operand.
    run_case(1, 3, 85, 24);
    for (int i = 0; i < 256; i++) begin
      run_case(1, i, ref_rcp(8, i), -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
